// File: rtl/led_ctl_pkg.sv
// Shared types and constants for the LED mode sequencer.
package led_ctl_pkg;

    typedef enum logic [1:0] {
        MODE_CYCLE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [3:0] FILL_MAX  = 4'd8;
    localparam logic [7:0] LED_RESET = 8'h80;

    // Position 0 lights the leftmost LED (bit 7).
    function automatic logic [7:0] pos_onehot(input logic [2:0] p);
        return 8'h80 >> p;
    endfunction

    function automatic logic [7:0] fill_bar(input logic [3:0] l);
        return ~(8'hFF >> l);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on an accepted 1->0 transition of the active-low input.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer resets to "released" so a sample in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/led_mode_controller.sv
// 8-LED sequencer: prescaler, mode FSM and CYCLE/BOUNCE/FILL/BLINK patterns.
// Optional PWM dimming when LED_PWM_EN is defined.
module led_mode_controller
    import led_ctl_pkg::*;
#(
    parameter int TICK_BITS       = 23,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int DIM_DUTY        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic       sw_dir,
    input  logic       sw_hold,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    logic                 press;
    logic                 btn_level;
    logic [TICK_BITS-1:0] pre_q, pre_d;
    logic                 tick_q, tick_d;
    mode_e                mode_q, mode_d;
    logic [2:0]           pos_q, pos_d;
    logic [3:0]           lvl_q, lvl_d;
    logic                 bdir_q, bdir_d;
    logic                 phase_q, phase_d;
    logic [7:0]           led_q, led_d;
    logic [7:0]           pat;
    logic                 advance;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (btn_n),
        .level_o (btn_level),
        .press_o (press)
    );

`ifdef LED_PWM_EN
    logic [3:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) pwm_q <= '0;
        else        pwm_q <= pwm_d;
    end
`endif

    // A press outranks a coincident tick: the mode change resets everything.
    assign advance = tick_q & ~sw_hold & ~press;

    always_comb begin
        pre_d   = pre_q + 1'b1;
        mode_d  = mode_q;
        pos_d   = pos_q;
        lvl_d   = lvl_q;
        bdir_d  = bdir_q;
        phase_d = phase_q;
        if (press) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            pos_d   = '0;
            lvl_d   = '0;
            bdir_d  = 1'b1;
            phase_d = 1'b1;
            pre_d   = '0;
        end else if (advance) begin
            unique case (mode_q)
                MODE_CYCLE:  pos_d = sw_dir ? pos_q + 3'd1 : pos_q - 3'd1;
                MODE_BOUNCE: begin
                    if (bdir_q) begin
                        if (pos_q == 3'd7) begin pos_d = 3'd6; bdir_d = 1'b0; end
                        else               pos_d = pos_q + 3'd1;
                    end else begin
                        if (pos_q == 3'd0) begin pos_d = 3'd1; bdir_d = 1'b1; end
                        else               pos_d = pos_q - 3'd1;
                    end
                end
                MODE_FILL: begin
                    if (sw_dir) lvl_d = (lvl_q >= FILL_MAX) ? 4'd0 : lvl_q + 4'd1;
                    else        lvl_d = (lvl_q == 4'd0) ? FILL_MAX : lvl_q - 4'd1;
                end
                MODE_BLINK:  phase_d = ~phase_q;
            endcase
        end
    end

    // Outputs are built from next state so they are registered yet current.
    always_comb begin
        tick_d = &pre_d;
        unique case (mode_d)
            MODE_CYCLE, MODE_BOUNCE: pat = pos_onehot(pos_d);
            MODE_FILL:               pat = fill_bar(lvl_d);
            MODE_BLINK:              pat = {8{phase_d}};
        endcase
`ifdef LED_PWM_EN
        led_d = pat & {8{({1'b0, pwm_d} < 5'(DIM_DUTY))}};
`else
        led_d = pat;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            mode_q  <= MODE_CYCLE;
            pos_q   <= '0;
            lvl_q   <= '0;
            bdir_q  <= 1'b1;
            phase_q <= 1'b1;
            led_q   <= LED_RESET;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            lvl_q   <= lvl_d;
            bdir_q  <= bdir_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Self-checking bench for led_mode_controller with TICK_BITS=3, DEBOUNCE_CYCLES=4.
module tb_led_mode_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_n = 1'b1;
    logic       sw_dir = 1'b1;
    logic       sw_hold = 1'b0;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];

    led_mode_controller #(
        .TICK_BITS       (3),
        .DEBOUNCE_CYCLES (4),
        .DIM_DUTY        (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n   (btn_n),
        .sw_dir  (sw_dir),
        .sw_hold (sw_hold),
        .led     (led),
        .mode    (mode),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_button();
        btn_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        sw_dir = 1'b1; sw_hold = 1'b0; btn_n = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (led !== 8'h80) $display("FAIL reset_led got %h want 80", led); else passed++;
        total++; if (mode !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode); else passed++;
        total++; if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else passed++;
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            total++;
            if (tick !== (c == 7)) $display("FAIL reset_tick_c%0d got %b want %b", c, tick, (c == 7));
            else passed++;
        end
    endtask

    task automatic test_cycle();
        logic [7:0] tbl [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        logic [7:0] e;
        bit ok;
        sw_dir = 1'b1;
        do_reset();
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL cycle_up tick timeout");
            else if (led !== e) $display("FAIL cycle_up led got %h want %h", led, e);
            else passed++;
        end
        sw_dir = 1'b0;
        do_reset();
        exp_q.push_back(8'h01);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL cycle_down tick timeout");
            else if (led !== e) $display("FAIL cycle_down led got %h want %h", led, e);
            else passed++;
        end
    endtask

    task automatic test_debounce();
        sw_dir = 1'b1;
        do_reset();
        sw_hold = 1'b1;
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (mode !== 2'd0) $display("FAIL glitch_mode got %0d want 0", mode); else passed++;
        btn_n = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            total++;
            if (mode !== ((c == 7) ? 2'd1 : 2'd0))
                $display("FAIL press_latency_c%0d mode got %0d want %0d", c, mode, (c == 7) ? 1 : 0);
            else passed++;
        end
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        total++; if (mode !== 2'd1) $display("FAIL release_mode got %0d want 1", mode); else passed++;
        total++; if (led !== 8'h80) $display("FAIL bounce_entry_led got %h want 80", led); else passed++;
    endtask

    task automatic test_bounce();
        logic [7:0] tbl [15] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                                 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
        logic [7:0] e;
        bit ok;
        do_reset();
        sw_hold = 1'b1;
        press_button();
        total++; if (mode !== 2'd1) $display("FAIL bounce_mode got %0d want 1", mode); else passed++;
        sw_hold = 1'b0;
        sw_dir = 1'b0;
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL bounce tick timeout");
            else if (led !== e) $display("FAIL bounce led got %h want %h", led, e);
            else passed++;
        end
    endtask

    task automatic test_fill_hold();
        logic [7:0] up [10] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00, 8'h80};
        logic [7:0] dn [3]  = '{8'h00, 8'hFF, 8'hFE};
        logic [7:0] e;
        bit ok;
        do_reset();
        sw_hold = 1'b1;
        press_button();
        press_button();
        total++; if (mode !== 2'd2) $display("FAIL fill_mode got %0d want 2", mode); else passed++;
        total++; if (led !== 8'h00) $display("FAIL fill_entry_led got %h want 00", led); else passed++;
        sw_dir = 1'b1;
        sw_hold = 1'b0;
        foreach (up[i]) exp_q.push_back(up[i]);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL fill_up tick timeout");
            else if (led !== e) $display("FAIL fill_up led got %h want %h", led, e);
            else passed++;
        end
        sw_hold = 1'b1;
        repeat (3) exp_q.push_back(8'h80);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL hold tick not pulsing");
            else if (led !== e) $display("FAIL hold led got %h want %h", led, e);
            else passed++;
        end
        sw_hold = 1'b0;
        sw_dir = 1'b0;
        foreach (dn[i]) exp_q.push_back(dn[i]);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL fill_down tick timeout");
            else if (led !== e) $display("FAIL fill_down led got %h want %h", led, e);
            else passed++;
        end
    endtask

    task automatic test_blink();
        logic [7:0] tbl [3] = '{8'h00, 8'hFF, 8'h00};
        logic [7:0] e;
        bit ok;
        sw_hold = 1'b1;
        press_button();
        total++; if (mode !== 2'd3) $display("FAIL blink_mode got %0d want 3", mode); else passed++;
        total++; if (led !== 8'hFF) $display("FAIL blink_entry_led got %h want FF", led); else passed++;
        sw_hold = 1'b0;
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL blink tick timeout");
            else if (led !== e) $display("FAIL blink led got %h want %h", led, e);
            else passed++;
        end
        sw_hold = 1'b1;
        press_button();
        total++; if (mode !== 2'd0) $display("FAIL mode_wrap got %0d want 0", mode); else passed++;
        total++; if (led !== 8'h80) $display("FAIL mode_wrap_led got %h want 80", led); else passed++;
    endtask

    task automatic test_collision();
        logic [7:0] e;
        bit ok;
        sw_dir = 1'b1;
        sw_hold = 1'b0;
        sw_hold = 1'b1;
        press_button();
        sw_hold = 1'b0;
        do_reset();
        total++; if (mode !== 2'd0) $display("FAIL midreset_mode got %0d want 0", mode); else passed++;
        total++; if (led !== 8'h80) $display("FAIL midreset_led got %h want 80", led); else passed++;
        // Falling edge before the 2nd clock lands the press pulse on the 8th cycle's tick.
        @(negedge clk);
        btn_n = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (tick !== 1'b1) $display("FAIL collide_tick got %b want 1", tick); else passed++;
        total++; if (mode !== 2'd0) $display("FAIL collide_premode got %0d want 0", mode); else passed++;
        @(negedge clk);
        total++; if (mode !== 2'd1) $display("FAIL collide_mode got %0d want 1", mode); else passed++;
        total++; if (led !== 8'h80) $display("FAIL collide_led got %h want 80", led); else passed++;
        btn_n = 1'b1;
        exp_q.push_back(8'h40);
        while (exp_q.size() > 0) begin
            wait_tick(ok);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (!ok) $display("FAIL collide_next tick timeout");
            else if (led !== e) $display("FAIL collide_next led got %h want %h", led, e);
            else passed++;
        end
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        int lit;
        do_reset();
        sw_hold = 1'b1;
        repeat (5) @(negedge clk);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led !== 8'h00) lit++;
        end
        total++; if (lit != 4) $display("FAIL pwm_duty lit %0d of 16 want 4", lit); else passed++;
    endtask
`endif

    initial begin
        test_reset();
`ifdef LED_PWM_EN
        test_pwm();
`else
        test_cycle();
        test_debounce();
        test_bounce();
        test_fill_hold();
        test_blink();
        test_collision();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
